// File: rtl/serial_sink_to_memory.sv
// serial_sink_to_memory: terminal receiver for the router serial data/busy link.
// Deserializes start-bit framed flits (LSB first, no stop bit) and captures
// them in arrival order into an internal memory with a random-access read port.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   serial_in      serial line from the transmitter (idle low)
//   channel_busy   hold-off to the transmitter
//   clear          synchronous pulse, empties the capture memory
//   rd_addr        read address; rd_data returns mem[rd_addr] one cycle later
//   flit_count     number of flits stored; full when it equals depth
//   dest_errors    destination-mismatch count (only with SINK_MEM_DEST_CHECK_EN)
//
// Optional feature macro: SINK_MEM_DEST_CHECK_EN enables the destination check.

module serial_sink_to_memory #(
   parameter int unsigned id         = 0,
   parameter int unsigned flit_width = 32,
   parameter int unsigned depth      = 256,
   parameter int unsigned addr_bits  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      serial_in,
   output logic                      channel_busy,
   input  logic                      clear,
   input  logic [$clog2(depth)-1:0]  rd_addr,
   output logic [flit_width-1:0]     rd_data,
   output logic [$clog2(depth):0]    flit_count,
   output logic                      full
`ifdef SINK_MEM_DEST_CHECK_EN
   ,
   output logic [15:0]               dest_errors
`endif
);

   localparam int unsigned AW = $clog2(depth);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(flit_width);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_STORE, S_FULL} state_t;

   state_t                state;
   logic [AW-1:0]         wr_ptr;
   logic [BW-1:0]         bit_cnt;
   logic [flit_width-1:0] shift_reg;
   logic [flit_width-1:0] mem [depth];

   // Status decoded purely from registers, no input-to-output path
   assign full         = (flit_count == CW'(depth));
   assign channel_busy = (state != S_IDLE) || full;

   // Receive FSM, write pointer and occupancy; clear is applied last so it wins
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         flit_count <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (full) begin
                  state <= S_FULL;
               end else if (serial_in && !clear) begin
                  state   <= S_SHIFT;
                  bit_cnt <= '0;
               end
            end
            S_SHIFT: begin
               // LSB arrives first, so shift in at the top and move right
               shift_reg <= {serial_in, shift_reg[flit_width-1:1]};
               bit_cnt   <= bit_cnt + BW'(1);
               if (bit_cnt == BW'(flit_width - 1)) state <= S_STORE;
            end
            S_STORE: begin
               wr_ptr     <= wr_ptr + AW'(1);
               flit_count <= flit_count + CW'(1);
               if (!clear && (flit_count == CW'(depth - 1))) state <= S_FULL;
               else                                          state <= S_IDLE;
            end
            S_FULL: begin
               if (clear) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (clear) begin
            wr_ptr     <= '0;
            flit_count <= '0;
         end
      end
   end

   // Capture memory write; contents survive reset and clear
   always_ff @(posedge clk) begin
      if (!reset && (state == S_STORE)) mem[wr_ptr] <= shift_reg;
   end

   // Registered read port; same-edge write returns the old value
   always_ff @(posedge clk) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

`ifdef SINK_MEM_DEST_CHECK_EN
   localparam logic [addr_bits-1:0] DEST_ID = addr_bits'(id);

   logic dest_miss_c;
   assign dest_miss_c = (state == S_STORE) && (shift_reg[addr_bits-1:0] != DEST_ID);

   // Saturating mismatch counter; the flit is stored either way
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         dest_errors <= '0;
      end else if (dest_miss_c && (dest_errors != 16'hFFFF)) begin
         dest_errors <= dest_errors + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && dest_miss_c)
         $display("serial_sink_to_memory id %0d: dest error at entry %0d flit %h",
                  id, wr_ptr, shift_reg);
   end
`else
   // Keep destination-check parameters referenced when the check is compiled out
   logic unused_dest_cfg;
   assign unused_dest_cfg = ^{32'(id), 32'(addr_bits)};
`endif

endmodule

// File: tb/tb_serial_sink_to_memory.sv
// Directed bench for serial_sink_to_memory: a depth-256 and a depth-4 instance
// share the same stimulus; each scenario resets both before it starts.
module tb_serial_sink_to_memory;

   logic        clk;
   logic        reset;
   logic        serial_in;
   logic        clear;
   logic [7:0]  rd_addr;
   logic        busy,  busy4;
   logic [31:0] rd_data, rd_data4;
   logic [8:0]  flit_count;
   logic [2:0]  flit_count4;
   logic        full, full4;
`ifdef SINK_MEM_DEST_CHECK_EN
   logic [15:0] dest_errors, dest_errors4;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   serial_sink_to_memory #(.id(4), .flit_width(32), .depth(256), .addr_bits(4)) dut (
      .clk(clk), .reset(reset), .serial_in(serial_in), .channel_busy(busy),
      .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
      .flit_count(flit_count), .full(full)
`ifdef SINK_MEM_DEST_CHECK_EN
      , .dest_errors(dest_errors)
`endif
   );

   serial_sink_to_memory #(.id(4), .flit_width(32), .depth(4), .addr_bits(4)) dut4 (
      .clk(clk), .reset(reset), .serial_in(serial_in), .channel_busy(busy4),
      .clear(clear), .rd_addr(rd_addr[1:0]), .rd_data(rd_data4),
      .flit_count(flit_count4), .full(full4)
`ifdef SINK_MEM_DEST_CHECK_EN
      , .dest_errors(dest_errors4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  addr;
   } vec_t;

   vec_t tv [10];
   vec_t dv [3];
   logic [31:0] d4 [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; serial_in = 1'b0; clear = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
   endtask

   task automatic rd(input logic [7:0] a);
      rd_addr = a;
      step();
   endtask

   // Waits for busy low (bounded), sends one frame; returns busy-high samples
   task automatic send_frame(input logic [31:0] data, input bit clr_store, output int busy_hi);
      int guard;
      guard = 0;
      while (busy && guard < 200) begin
         step();
         guard++;
      end
      if (guard >= 200) check("wait_idle", 64'(busy), 64'(0));
      busy_hi = 0;
      serial_in = 1'b1;
      step();
      for (int i = 0; i < 32; i++) begin
         busy_hi += int'(busy);
         serial_in = data[i];
         step();
      end
      busy_hi += int'(busy);
      serial_in = 1'b0;
      if (clr_store) clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      int bh;
      logic [31:0] pd;

      tv[0] = '{32'h0000_0000, 8'd0}; tv[1] = '{32'h0000_0001, 8'd1};
      tv[2] = '{32'h0000_0002, 8'd2}; tv[3] = '{32'h0000_0003, 8'd3};
      tv[4] = '{32'h0000_0004, 8'd4}; tv[5] = '{32'h0000_0005, 8'd5};
      tv[6] = '{32'h0000_0006, 8'd6}; tv[7] = '{32'h0000_0007, 8'd7};
      tv[8] = '{32'h0000_0008, 8'd8}; tv[9] = '{32'h0000_0009, 8'd9};
      dv[0] = '{32'hD0D0_0004, 8'd0};
      dv[1] = '{32'hD1D1_0007, 8'd1};
      dv[2] = '{32'hD2D2_0014, 8'd2};
      d4[0] = 32'h1111_0011; d4[1] = 32'h2222_0022;
      d4[2] = 32'h3333_0033; d4[3] = 32'h4444_0044;

      reset = 1'b1; serial_in = 1'b0; clear = 1'b0; rd_addr = '0;

      // Reset state, sampled while reset is held
      step(); step();
      check("rst_busy",  64'(busy),       64'(0));
      check("rst_count", 64'(flit_count), 64'(0));
      check("rst_full",  64'(full),       64'(0));
      check("rst_rdata", 64'(rd_data),    64'(0));
      check("rst_busy4", 64'(busy4),      64'(0));
      check("rst_rdata4",64'(rd_data4),   64'(0));
`ifdef SINK_MEM_DEST_CHECK_EN
      check("rst_dest_err", 64'(dest_errors), 64'(0));
`endif
      reset = 1'b0;
      step();

      // Single frame
      send_frame(32'hA5A5_0004, 1'b0, bh);
      check("t1_busy_cycles", 64'(bh), 64'(33));
      check("t1_busy_after",  64'(busy), 64'(0));
      check("t1_count",       64'(flit_count), 64'(1));
      rd(8'd0);
      check("t1_rdata", 64'(rd_data), 64'h0000_0000_A5A5_0004);

      // Back-to-back frames, each started the cycle busy falls
      do_reset();
      for (int i = 0; i < 10; i++) begin
         send_frame(tv[i].data, 1'b0, bh);
         check($sformatf("t2_busy_cycles[%0d]", i), 64'(bh), 64'(33));
         check($sformatf("t2_busy_low[%0d]", i), 64'(busy), 64'(0));
      end
      check("t2_count", 64'(flit_count), 64'(10));
      for (int i = 0; i < 10; i++) begin
         rd(tv[i].addr);
         check($sformatf("t2_rdata[%0d]", i), 64'(rd_data), 64'(tv[i].data));
      end

      // depth=4 fill, ignored 5th start, clear
      do_reset();
      for (int i = 0; i < 4; i++) send_frame(d4[i], 1'b0, bh);
      check("t3_full4",  64'(full4),       64'(1));
      check("t3_busy4",  64'(busy4),       64'(1));
      check("t3_count4", 64'(flit_count4), 64'(4));
      send_frame(32'h5555_0055, 1'b0, bh);
      check("t3_count4_5th", 64'(flit_count4), 64'(4));
      check("t3_busy4_5th",  64'(busy4),       64'(1));
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t3_busy4_clr",  64'(busy4),       64'(0));
      check("t3_count4_clr", 64'(flit_count4), 64'(0));
      check("t3_full4_clr",  64'(full4),       64'(0));
      send_frame(32'h6666_0066, 1'b0, bh);
      check("t3_count4_new", 64'(flit_count4), 64'(1));
      rd(8'd0);
      check("t3_rdata4_e0", 64'(rd_data4), 64'h0000_0000_6666_0066);
      rd(8'd1);
      check("t3_rdata4_e1", 64'(rd_data4), 64'h0000_0000_2222_0022);

      // Reset at data bit 17 of a frame
      do_reset();
      send_frame(32'h0BAD_BEEF, 1'b0, bh);
      check("t4_count_pre", 64'(flit_count), 64'(1));
      pd = 32'h1234_5678;
      serial_in = 1'b1;
      step();
      for (int i = 0; i < 17; i++) begin
         serial_in = pd[i];
         step();
      end
      check("t4_busy_mid", 64'(busy), 64'(1));
      reset = 1'b1;
      serial_in = pd[17];
      step();
      check("t4_rst_busy",  64'(busy),       64'(0));
      check("t4_rst_count", 64'(flit_count), 64'(0));
      check("t4_rst_full",  64'(full),       64'(0));
      check("t4_rst_rdata", 64'(rd_data),    64'(0));
      reset = 1'b0;
      serial_in = 1'b0;
      step();
      send_frame(32'hCAFE_F00D, 1'b0, bh);
      check("t4_count_post", 64'(flit_count), 64'(1));
      rd(8'd0);
      check("t4_rdata", 64'(rd_data), 64'h0000_0000_CAFE_F00D);

      // Clear coincident with the store of the 3rd flit
      do_reset();
      send_frame(32'h1111_0001, 1'b0, bh);
      send_frame(32'h2222_0002, 1'b0, bh);
      send_frame(32'h3333_0003, 1'b1, bh);
      check("t5_count_clr", 64'(flit_count), 64'(0));
      check("t5_busy_clr",  64'(busy),       64'(0));
      rd(8'd2);
      check("t5_rdata_e2", 64'(rd_data), 64'h0000_0000_3333_0003);
      send_frame(32'h4444_0004, 1'b0, bh);
      check("t5_count_new", 64'(flit_count), 64'(1));
      rd(8'd0);
      check("t5_rdata_e0", 64'(rd_data), 64'h0000_0000_4444_0004);

      // Destinations 4, 7, 4 with id=4
      do_reset();
      for (int i = 0; i < 3; i++) send_frame(dv[i].data, 1'b0, bh);
      check("t6_count", 64'(flit_count), 64'(3));
`ifdef SINK_MEM_DEST_CHECK_EN
      check("t6_dest_errors", 64'(dest_errors), 64'(1));
`endif
      for (int i = 0; i < 3; i++) begin
         rd(dv[i].addr);
         check($sformatf("t6_rdata[%0d]", i), 64'(rd_data), 64'(dv[i].data));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
